mc_control_unit: RTL and testbench

- Multi-cycle control FSM for the 16-bit accumulator datapath.
- Sequences the single shared ALU through fetch, PC increment, operand read, execute, load/store, jump and branch-on-zero.
- Drives memory strobes, register write enables, ALU operand selects and ALU function.
- Waits on a memory ready handshake, with a watchdog that halts the core on a stuck memory.

---
 rtl/mc_control_unit.sv | 169 ++++++++++++++++
 tb/tb_mc_control_unit.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/mc_control_unit.sv
// Multi-cycle control FSM for the 16-bit accumulator datapath.
// Sequences the shared ALU, memory strobes and register enables; a watchdog halts on stuck memory.
module mc_control_unit #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opcode,
  input  logic       mem_ready,
  input  logic       zero,
  output logic       mem_read,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       mdr_write,
  output logic       acc_write,
  output logic       acc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_func,
  output logic       pc_load,
  output logic       pc_src,
  output logic       halted,
  output logic       mem_err,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    S_START   = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEM_RD  = 4'd3,
    S_EXEC    = 4'd4,
    S_LOAD_WB = 4'd5,
    S_MEM_WR  = 4'd6,
    S_JUMP    = 4'd7,
    S_BRZ     = 4'd8,
    S_HALT    = 4'd9
  } state_t;

  localparam logic [2:0] OP_NOT = 3'b011;
  localparam logic [2:0] OP_LDA = 3'b100;
  localparam logic [2:0] OP_STA = 3'b101;
  localparam logic [2:0] OP_JMP = 3'b110;
  localparam logic [2:0] OP_JZ  = 3'b111;

  // Wide enough to hold MEM_TIMEOUT itself, the last cycle number k of a wait.
  localparam int CW = $clog2(MEM_TIMEOUT + 2);

  state_t          state_q, state_d;
  logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
  logic            mem_err_q, mem_err_d;
  logic [CW-1:0]   wait_k;
  logic            waiting;
  logic            timeout_hit;

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = '0;
    mem_err_d   = mem_err_q;
    waiting     = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    i_or_d      = 1'b0;
    ir_write    = 1'b0;
    mdr_write   = 1'b0;
    acc_write   = 1'b0;
    acc_src     = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_func    = 2'b00;
    pc_load     = 1'b0;
    pc_src      = 1'b0;
    wait_k      = wait_cnt_q + CW'(1);
    timeout_hit = (MEM_TIMEOUT != 0) && (wait_k == CW'(MEM_TIMEOUT)) && !mem_ready;

    case (state_q)
      S_START: state_d = S_FETCH;
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_load  = 1'b1;
          state_d  = S_DECODE;
        end else begin
          waiting = 1'b1;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_NOT:  state_d = S_EXEC;
          OP_STA:  state_d = S_MEM_WR;
          OP_JMP:  state_d = S_JUMP;
          OP_JZ:   state_d = S_BRZ;
          default: state_d = S_MEM_RD;
        endcase
      end
      S_MEM_RD: begin
        mem_read  = 1'b1;
        i_or_d    = 1'b1;
        mdr_write = mem_ready;
        if (mem_ready) begin
          state_d = (opcode == OP_LDA) ? S_LOAD_WB : S_EXEC;
        end else begin
          waiting = 1'b1;
        end
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_func  = opcode[1:0];
        acc_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_LOAD_WB: begin
        acc_write = 1'b1;
        acc_src   = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) state_d = S_FETCH;
        else           waiting = 1'b1;
      end
      S_JUMP: begin
        pc_load = 1'b1;
        pc_src  = 1'b1;
        state_d = S_FETCH;
      end
      S_BRZ: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b11;
        pc_load   = zero;
        pc_src    = 1'b1;
        state_d   = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_START;
    endcase

    // Counting only while a wait continues means any entry into a wait starts from zero.
    if (waiting) begin
      if (timeout_hit) begin
        state_d   = S_HALT;
        mem_err_d = 1'b1;
      end else begin
        wait_cnt_d = wait_k;
      end
    end

    if (rst) begin
      state_d    = S_START;
      wait_cnt_d = '0;
      mem_err_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    state_q    <= state_d;
    wait_cnt_q <= wait_cnt_d;
    mem_err_q  <= mem_err_d;
  end

  assign halted    = (state_q == S_HALT);
  assign mem_err   = mem_err_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Scoreboard bench for mc_control_unit: directed per-cycle vectors push expected outputs,
// a negedge monitor pops and compares against the full output bundle.
module tb_mc_control_unit;

  logic       clk;
  logic       rst;
  logic [2:0] opcode;
  logic       mem_ready;
  logic       zero;
  logic       mem_read, mem_write, i_or_d, ir_write, mdr_write;
  logic       acc_write, acc_src, alu_src_a, pc_load, pc_src, halted, mem_err;
  logic [1:0] alu_src_b, alu_func;
  logic [3:0] state_dbg;

  logic [19:0] expQ[$];
  string       nameQ[$];
  int          total = 0;
  int          bad   = 0;
  logic [19:0] actVec;

  mc_control_unit #(.MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready), .zero(zero),
    .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d), .ir_write(ir_write),
    .mdr_write(mdr_write), .acc_write(acc_write), .acc_src(acc_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_func(alu_func), .pc_load(pc_load), .pc_src(pc_src),
    .halted(halted), .mem_err(mem_err), .state_dbg(state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign actVec = {mem_read, mem_write, i_or_d, ir_write, mdr_write, acc_write, acc_src,
                   alu_src_a, alu_src_b, alu_func, pc_load, pc_src, halted, mem_err, state_dbg};

  // Hand-written table of what each state should present, with the Mealy terms as arguments.
  function automatic logic [19:0] expVec(input int st, input logic rdy, input logic zr,
                                         input logic err, input logic [1:0] fn);
    logic mr, mw, iod, irw, mdw, aw, as, sa, pl, ps, hl;
    logic [1:0] sb, f;
    {mr, mw, iod, irw, mdw, aw, as, sa, pl, ps, hl} = '0;
    sb = 2'b00;
    f  = 2'b00;
    case (st)
      1: begin mr = 1; sb = 2'b01; irw = rdy; pl = rdy; end
      3: begin mr = 1; iod = 1; mdw = rdy; end
      4: begin sa = 1; f = fn; aw = 1; end
      5: begin aw = 1; as = 1; end
      6: begin mw = 1; iod = 1; end
      7: begin pl = 1; ps = 1; end
      8: begin sa = 1; sb = 2'b11; pl = zr; ps = 1; end
      9: hl = 1;
      default: ;
    endcase
    return {mr, mw, iod, irw, mdw, aw, as, sa, sb, f, pl, ps, hl, err, 4'(st)};
  endfunction

  task automatic applyStimulus(input logic r, input logic [2:0] op, input logic rdy,
                               input logic zr, input int st, input logic err,
                               input logic [1:0] fn, input string nm);
    @(posedge clk);
    #1;
    rst       = r;
    opcode    = op;
    mem_ready = rdy;
    zero      = zr;
    expQ.push_back(expVec(st, rdy, zr, err, fn));
    nameQ.push_back(nm);
  endtask

  task automatic checkOutput(input logic [19:0] exp, input string nm);
    total++;
    if (actVec !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%05h (state %0d) want=%05h (state %0d)",
               nm, actVec, actVec[3:0], exp, exp[3:0]);
    end
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      checkOutput(expQ.pop_front(), nameQ.pop_front());
    end
  end

  initial begin
    rst       = 1'b1;
    opcode    = 3'b000;
    mem_ready = 1'b0;
    zero      = 1'b0;

    applyStimulus(1, 3'b000, 0, 0, 0, 0, 2'b00, "reset1");
    applyStimulus(1, 3'b000, 1, 0, 0, 0, 2'b00, "reset2");
    applyStimulus(0, 3'b000, 1, 0, 0, 0, 2'b00, "start");

    // ADD: 1,2,3,4,1
    applyStimulus(0, 3'b000, 1, 0, 1, 0, 2'b00, "add_fetch");
    applyStimulus(0, 3'b000, 1, 0, 2, 0, 2'b00, "add_decode");
    applyStimulus(0, 3'b000, 1, 0, 3, 0, 2'b00, "add_memrd");
    applyStimulus(0, 3'b000, 1, 0, 4, 0, 2'b00, "add_exec");
    // SUB
    applyStimulus(0, 3'b001, 1, 0, 1, 0, 2'b00, "sub_fetch");
    applyStimulus(0, 3'b001, 1, 0, 2, 0, 2'b00, "sub_decode");
    applyStimulus(0, 3'b001, 1, 0, 3, 0, 2'b00, "sub_memrd");
    applyStimulus(0, 3'b001, 1, 0, 4, 0, 2'b01, "sub_exec");
    // AND
    applyStimulus(0, 3'b010, 1, 0, 1, 0, 2'b00, "and_fetch");
    applyStimulus(0, 3'b010, 1, 0, 2, 0, 2'b00, "and_decode");
    applyStimulus(0, 3'b010, 1, 0, 3, 0, 2'b00, "and_memrd");
    applyStimulus(0, 3'b010, 1, 0, 4, 0, 2'b10, "and_exec");
    // NOT: 1,2,4,1
    applyStimulus(0, 3'b011, 1, 0, 1, 0, 2'b00, "not_fetch");
    applyStimulus(0, 3'b011, 1, 0, 2, 0, 2'b00, "not_decode");
    applyStimulus(0, 3'b011, 1, 0, 4, 0, 2'b11, "not_exec");

    // LDA with three wait cycles in MEM_RD
    applyStimulus(0, 3'b100, 1, 0, 1, 0, 2'b00, "lda_fetch");
    applyStimulus(0, 3'b100, 1, 0, 2, 0, 2'b00, "lda_decode");
    for (int i = 0; i < 3; i++) applyStimulus(0, 3'b100, 0, 0, 3, 0, 2'b00, "lda_wait");
    applyStimulus(0, 3'b100, 1, 0, 3, 0, 2'b00, "lda_memrd");
    applyStimulus(0, 3'b100, 1, 0, 5, 0, 2'b00, "lda_loadwb");

    // FETCH waits too
    applyStimulus(0, 3'b111, 0, 1, 1, 0, 2'b00, "fetch_wait");
    applyStimulus(0, 3'b111, 1, 1, 1, 0, 2'b00, "jz1_fetch");
    applyStimulus(0, 3'b111, 1, 1, 2, 0, 2'b00, "jz1_decode");
    applyStimulus(0, 3'b111, 1, 1, 8, 0, 2'b00, "jz1_brz");
    applyStimulus(0, 3'b111, 1, 0, 1, 0, 2'b00, "jz0_fetch");
    applyStimulus(0, 3'b111, 1, 0, 2, 0, 2'b00, "jz0_decode");
    applyStimulus(0, 3'b111, 1, 0, 8, 0, 2'b00, "jz0_brz");
    applyStimulus(0, 3'b110, 1, 0, 1, 0, 2'b00, "jmp_fetch");
    applyStimulus(0, 3'b110, 1, 0, 2, 0, 2'b00, "jmp_decode");
    applyStimulus(0, 3'b110, 1, 0, 7, 0, 2'b00, "jmp_jump");

    // STA with a stuck memory: 15 MEM_WR cycles, then HALT
    applyStimulus(0, 3'b101, 1, 0, 1, 0, 2'b00, "sta_fetch");
    applyStimulus(0, 3'b101, 1, 0, 2, 0, 2'b00, "sta_decode");
    for (int i = 0; i < 15; i++) applyStimulus(0, 3'b101, 0, 0, 6, 0, 2'b00, "sta_stuck");
    for (int i = 0; i < 20; i++) applyStimulus(0, 3'b101, i[0], 0, 9, 1, 2'b00, "halt_hold");
    applyStimulus(1, 3'b101, 0, 0, 9, 1, 2'b00, "halt_rst");
    applyStimulus(0, 3'b101, 0, 0, 0, 0, 2'b00, "halt_start");

    // STA with ready arriving on the 15th wait cycle
    applyStimulus(0, 3'b101, 1, 0, 1, 0, 2'b00, "sta2_fetch");
    applyStimulus(0, 3'b101, 1, 0, 2, 0, 2'b00, "sta2_decode");
    for (int i = 0; i < 14; i++) applyStimulus(0, 3'b101, 0, 0, 6, 0, 2'b00, "sta2_wait");
    applyStimulus(0, 3'b101, 1, 0, 6, 0, 2'b00, "sta2_k15");
    applyStimulus(0, 3'b000, 1, 0, 1, 0, 2'b00, "sta2_after");

    // Reset mid MEM_RD, then a full-length wait must still complete
    applyStimulus(0, 3'b000, 1, 0, 2, 0, 2'b00, "mid_decode");
    for (int i = 0; i < 5; i++) applyStimulus(0, 3'b000, 0, 0, 3, 0, 2'b00, "mid_wait");
    applyStimulus(1, 3'b000, 0, 0, 3, 0, 2'b00, "mid_rst");
    applyStimulus(0, 3'b000, 0, 0, 0, 0, 2'b00, "mid_start");
    applyStimulus(0, 3'b000, 1, 0, 1, 0, 2'b00, "mid_fetch");
    applyStimulus(0, 3'b000, 1, 0, 2, 0, 2'b00, "mid_decode2");
    for (int i = 0; i < 14; i++) applyStimulus(0, 3'b000, 0, 0, 3, 0, 2'b00, "mid_wait2");
    applyStimulus(0, 3'b000, 1, 0, 3, 0, 2'b00, "mid_memrd_k15");
    applyStimulus(0, 3'b000, 1, 0, 4, 0, 2'b00, "mid_exec");
    applyStimulus(0, 3'b000, 1, 0, 1, 0, 2'b00, "mid_refetch");

    for (int i = 0; i < 10 && expQ.size() != 0; i++) @(negedge clk);
    #1;
    if (expQ.size() != 0) begin
      bad++;
      total++;
      $display("[TB] FAIL drain: got=%0d pending want=0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
